counter_pad_ctrl: RTL and testbench
===================================

// Module: counter_pad_ctrl
// PURPOSE
// Pad-bus controller between the shared bidirectional digital pads and the loadable counter core.
// Synchronises the external oeb/web strobes and arbitrates the shared W-bit pad bus (drive count out vs. accept a load value in).
// Inserts bus-turnaround gaps, debounces load data, and gates the counter enable. Sits in the chip top between the pad ring and the counter.
// PARAMETERS
// W              41  counter / pad-bus width
// TURN_CYCLES     2  hi-z cycles inserted on every bus direction change (>=1)
// STABLE_CYCLES   3  consecutive identical pad_in samples required before a load (>=1)
// PORTS
// clk           in   1  core clock
// rst_n         in   1  asynchronous active-low reset
// oeb_pad       in   1  raw pad, active-low "drive count onto bus", asynchronous to clk
// web_pad       in   1  raw pad, active-low "write load value from bus", asynchronous to clk
// pad_in        in   W  pad input buffers
// pad_out       out  W  pad output data
// pad_oe        out  W  per-bit pad drive enable, active-high, all bits identical
// cnt_q         in   W  current counter value from core
// cnt_en        out  1  counter count enable
// cnt_load      out  1  one-cycle load strobe to core (core loads on next edge, overrides cnt_en)
// cnt_load_val  out  W  value to load, valid while cnt_load=1
// busy          out  1  state != IDLE
// BEHAVIOUR
// - All outputs registered. Reset (async, immediate): state IDLE, pad_oe=0, pad_out=0, cnt_en=0, cnt_load=0, cnt_load_val=0, sync/stable counters 0.
// - cnt_en=1 from first edge after reset release, except in WRITE/DONE (count frozen while a load is pending).
// - oeb_pad, web_pad: 2-FF synchronisers; oeb_s, web_s sampled at edge n+2 after pad change.
// - pad_in: one capture register per cycle (samp); stability counter covers metastability.
// - Priority: web_s=0 beats oeb_s=0. Controller never drives while web_s=0 -> no contention.
// - FSM:
//   IDLE : web_s=0 -> WRITE; else oeb_s=0 -> TURN (target DRIVE).
//   TURN : pad_oe=0, count TURN_CYCLES edges, then go to target.
//          Target re-evaluated on exit: if target's condition no longer holds -> IDLE (or WRITE if web_s=0).
//   DRIVE: pad_oe=all-1, pad_out<=cnt_q each edge (1-cycle latency).
//          oeb_s=1 or web_s=0 -> TURN (target IDLE/WRITE), pad_oe drops on that same edge.
//   WRITE: pad_oe=0. stab counter: samp==prev -> +1 (saturating), else reset to 0.
//          Counter reaches STABLE_CYCLES-1 (STABLE_CYCLES equal samples) -> cnt_load=1 for exactly one cycle, cnt_load_val=samp, go DONE.
//          web_s=1 before then -> abort, no load, go IDLE.
//   DONE : wait web_s=1 -> IDLE. One load per web low pulse, regardless of duration.
// - Latency, oeb_pad low sampled edge 0: TURN from edge 3, DRIVE + pad_oe=1 from edge 3+TURN_CYCLES.
// - Latency, web_pad low: WRITE from edge 3. Stable bus: cnt_load at edge 3+STABLE_CYCLES.
// - oeb/web both low: WRITE; drive resumes via TURN only after web release.
// - Glitch shorter than sync window: may be missed, never produces partial drive shorter than TURN.
// - Mid-operation reset: pad_oe deasserts asynchronously, pending load discarded.
// STRUCTURE
// - Package counter_pad_pkg: state enum {IDLE, TURN, DRIVE, WRITE, DONE}, counter-width localparams derived via $clog2(TURN_CYCLES+1), $clog2(STABLE_CYCLES+1).
// - Sub-module pad_sync: 2-FF async-reset synchroniser, reset value 1 (inactive), instantiated for oeb and web.
// - FSM, turnaround counter, stability counter, output registers in this module.
// TESTING (W=41, TURN_CYCLES=2, STABLE_CYCLES=3)
// - Reset with oeb/web=1: pad_oe=0, cnt_en=1 after first edge, busy=0. Assert rst_n mid-DRIVE -> pad_oe=0 without clock.
// - oeb_pad low at edge 0, cnt_q=41'h1_2345_6789: pad_oe=all-1 from edge 5; pad_out tracks cnt_q 1 cycle late.
//   oeb high -> pad_oe=0 within 3 edges; 2 hi-z cycles before IDLE.
// - web low, pad_in=41'h0_0000_00FF stable: single cnt_load pulse at edge 6 with val 0x0FF, cnt_en=0 until web high.
//   Hold web low 50 cycles -> still one pulse.
// - web low, pad_in toggling every cycle, then web high: no cnt_load, FSM returns to IDLE.
// - oeb and web low together: pad_oe never asserted; load completes. Release web with oeb still low -> DRIVE after TURN.
// - web asserted while in DRIVE: pad_oe drops on the edge after web_s=0. 2 TURN cycles, then WRITE. Load value = bus value, not last driven count.

Source files
------------

// File: rtl/counter_pad_ctrl_pkg.sv
// Shared types and sizing helpers for the pad-bus controller.
package counter_pad_pkg;

    typedef enum logic [2:0] {IDLE, TURN, DRIVE, WRITE, DONE} state_t;

    localparam int DEF_W             = 41;
    localparam int DEF_TURN_CYCLES   = 2;
    localparam int DEF_STABLE_CYCLES = 3;

    localparam int TURN_W = $clog2(DEF_TURN_CYCLES + 1);
    localparam int STAB_W = $clog2(DEF_STABLE_CYCLES + 1);

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/counter_pad_ctrl_pad_sync.sv
// Two-flop synchroniser for an active-low pad strobe; resets to the inactive level.
module pad_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/counter_pad_ctrl.sv
// Arbitrates the shared pad bus between driving the count out and accepting a
// debounced load value, with hi-z turnaround gaps on every direction change.
module counter_pad_ctrl
    import counter_pad_pkg::*;
#(
    parameter int W             = DEF_W,
    parameter int TURN_CYCLES   = DEF_TURN_CYCLES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         oeb_pad,
    input  logic         web_pad,
    input  logic [W-1:0] pad_in,
    output logic [W-1:0] pad_out,
    output logic [W-1:0] pad_oe,
    input  logic [W-1:0] cnt_q,
    output logic         cnt_en,
    output logic         cnt_load,
    output logic [W-1:0] cnt_load_val,
    output logic         busy
);

    localparam int TW = cnt_width(TURN_CYCLES);
    localparam int SW = cnt_width(STABLE_CYCLES);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);

    logic          oeb_s;
    logic          web_s;
    state_t        state;
    state_t        target;
    logic [TW-1:0] turn_cnt;
    logic [SW-1:0] stab_cnt;
    logic [W-1:0]  samp;
    logic [W-1:0]  prev;

    pad_sync u_oeb_sync (.clk(clk), .rst_n(rst_n), .d(oeb_pad), .q(oeb_s));
    pad_sync u_web_sync (.clk(clk), .rst_n(rst_n), .d(web_pad), .q(web_s));

    // Bus capture is not synchronised; the stability counter absorbs metastable samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp <= '0;
            prev <= '0;
        end else begin
            samp <= pad_in;
            prev <= samp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            target       <= IDLE;
            turn_cnt     <= '0;
            stab_cnt     <= '0;
            pad_oe       <= '0;
            pad_out      <= '0;
            cnt_en       <= 1'b0;
            cnt_load     <= 1'b0;
            cnt_load_val <= '0;
            busy         <= 1'b0;
        end else begin
            cnt_en   <= 1'b1;
            cnt_load <= 1'b0;
            busy     <= 1'b1;
            pad_oe   <= '0;
            pad_out  <= '0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (!web_s) begin
                        state    <= WRITE;
                        stab_cnt <= '0;
                        cnt_en   <= 1'b0;
                        busy     <= 1'b1;
                    end else if (!oeb_s) begin
                        state    <= TURN;
                        target   <= DRIVE;
                        turn_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        // A pending write always wins, whatever the turnaround was for.
                        if (!web_s) begin
                            state    <= WRITE;
                            stab_cnt <= '0;
                            cnt_en   <= 1'b0;
                        end else if (target == DRIVE && !oeb_s) begin
                            state   <= DRIVE;
                            pad_oe  <= '1;
                            pad_out <= cnt_q;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (oeb_s || !web_s) begin
                        state    <= TURN;
                        target   <= web_s ? IDLE : WRITE;
                        turn_cnt <= '0;
                    end else begin
                        pad_oe  <= '1;
                        pad_out <= cnt_q;
                    end
                end
                WRITE: begin
                    if (web_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt_en <= 1'b0;
                        if (samp == prev) begin
                            if (stab_cnt == STAB_LAST) begin
                                cnt_load     <= 1'b1;
                                cnt_load_val <= samp;
                                state        <= DONE;
                            end else begin
                                stab_cnt <= stab_cnt + 1'b1;
                            end
                        end else begin
                            stab_cnt <= '0;
                        end
                    end
                end
                DONE: begin
                    if (web_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt_en <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_pad_ctrl.sv
// Directed vector bench for counter_pad_ctrl: cycle-exact drive/write tables
// plus hand-written sequences for long holds, noisy bus, overlap and reset.
module tb_counter_pad_ctrl;

    localparam int W = 41;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         oeb_pad;
    logic         web_pad;
    logic [W-1:0] pad_in;
    logic [W-1:0] pad_out;
    logic [W-1:0] pad_oe;
    logic [W-1:0] cnt_q;
    logic         cnt_en;
    logic         cnt_load;
    logic [W-1:0] cnt_load_val;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [W-1:0] ALL1 = '1;
    localparam logic [W-1:0] VA = 41'h1_2345_6789;
    localparam logic [W-1:0] VB = 41'h0_ABCD_0123;
    localparam logic [W-1:0] VC = 41'h1_FFFF_0000;
    localparam logic [W-1:0] VP = 41'h0_0000_00FF;
    localparam logic [W-1:0] VQ = 41'h0_5555_AAAA;

    typedef struct {
        string        name;
        logic         oeb;
        logic         web;
        logic [W-1:0] pin;
        logic [W-1:0] cq;
        logic         exp_oe;
        logic         exp_en;
        logic         exp_load;
        logic         exp_busy;
        logic [W-1:0] exp_out;
        logic [W-1:0] exp_val;
    } vec_t;

    vec_t tbl[$];

    counter_pad_ctrl #(.W(W), .TURN_CYCLES(2), .STABLE_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .oeb_pad(oeb_pad), .web_pad(web_pad),
        .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe), .cnt_q(cnt_q),
        .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic oeb, input logic web,
                           input logic [W-1:0] pin, input logic [W-1:0] cq,
                           input logic oe, input logic en, input logic ld, input logic bsy,
                           input logic [W-1:0] out, input logic [W-1:0] val);
        vec_t v;
        v.name = name; v.oeb = oeb; v.web = web; v.pin = pin; v.cq = cq;
        v.exp_oe = oe; v.exp_en = en; v.exp_load = ld; v.exp_busy = bsy;
        v.exp_out = out; v.exp_val = val;
        tbl.push_back(v);
    endtask

    task automatic apply_stimulus(input vec_t v);
        oeb_pad = v.oeb;
        web_pad = v.web;
        pad_in  = v.pin;
        cnt_q   = v.cq;
    endtask

    task automatic check_vec(input vec_t v, input int i);
        check_output($sformatf("%s[%0d].pad_oe", v.name, i), 64'(pad_oe), 64'({W{v.exp_oe}}));
        check_output($sformatf("%s[%0d].cnt_en", v.name, i), 64'(cnt_en), 64'(v.exp_en));
        check_output($sformatf("%s[%0d].cnt_load", v.name, i), 64'(cnt_load), 64'(v.exp_load));
        check_output($sformatf("%s[%0d].busy", v.name, i), 64'(busy), 64'(v.exp_busy));
        if (v.exp_oe)
            check_output($sformatf("%s[%0d].pad_out", v.name, i), 64'(pad_out), 64'(v.exp_out));
        if (v.exp_load)
            check_output($sformatf("%s[%0d].load_val", v.name, i), 64'(cnt_load_val), 64'(v.exp_val));
    endtask

    task automatic idle_inputs(input int cycles);
        oeb_pad = 1'b1;
        web_pad = 1'b1;
        for (int c = 0; c < cycles; c++) step();
    endtask

    initial begin
        int loads;
        logic [W-1:0] last_val;
        logic [W-1:0] notp;
        logic drove;
        logic idle_seen;

        // Each entry is applied just after an edge and checked just after the next one.
        add_vec("drv", 0, 1, VP, VA, 0, 1, 0, 0, '0, '0);
        add_vec("drv", 0, 1, VP, VA, 0, 1, 0, 0, '0, '0);
        add_vec("drv", 0, 1, VP, VA, 0, 1, 0, 1, '0, '0);
        add_vec("drv", 0, 1, VP, VA, 0, 1, 0, 1, '0, '0);
        add_vec("drv", 0, 1, VP, VA, 1, 1, 0, 1, VA, '0);
        add_vec("drv", 0, 1, VP, VB, 1, 1, 0, 1, VB, '0);
        add_vec("drv", 1, 1, VP, VC, 1, 1, 0, 1, VC, '0);
        add_vec("drv", 1, 1, VP, VC, 1, 1, 0, 1, VC, '0);
        add_vec("drv", 1, 1, VP, VC, 0, 1, 0, 1, '0, '0);
        add_vec("drv", 1, 1, VP, VC, 0, 1, 0, 1, '0, '0);
        add_vec("drv", 1, 1, VP, VC, 0, 1, 0, 0, '0, '0);
        add_vec("wr", 1, 0, VP, VC, 0, 1, 0, 0, '0, '0);
        add_vec("wr", 1, 0, VP, VC, 0, 1, 0, 0, '0, '0);
        add_vec("wr", 1, 0, VP, VC, 0, 0, 0, 1, '0, '0);
        add_vec("wr", 1, 0, VP, VC, 0, 0, 0, 1, '0, '0);
        add_vec("wr", 1, 0, VP, VC, 0, 0, 0, 1, '0, '0);
        add_vec("wr", 1, 0, VP, VC, 0, 0, 1, 1, '0, VP);
        add_vec("wr", 1, 0, VP, VC, 0, 0, 0, 1, '0, '0);
        add_vec("wr", 1, 1, VP, VC, 0, 0, 0, 1, '0, '0);
        add_vec("wr", 1, 1, VP, VC, 0, 0, 0, 1, '0, '0);
        add_vec("wr", 1, 1, VP, VC, 0, 1, 0, 0, '0, '0);

        rst_n = 1'b0; oeb_pad = 1'b1; web_pad = 1'b1; pad_in = VP; cnt_q = '0;
        step(); step();
        check_output("rst.pad_oe", 64'(pad_oe), 64'(0));
        check_output("rst.cnt_en", 64'(cnt_en), 64'(0));
        check_output("rst.busy", 64'(busy), 64'(0));
        check_output("rst.cnt_load", 64'(cnt_load), 64'(0));
        rst_n = 1'b1;
        step();
        check_output("rst_rel.cnt_en", 64'(cnt_en), 64'(1));
        check_output("rst_rel.busy", 64'(busy), 64'(0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus(tbl[i]);
            step();
            check_vec(tbl[i], i);
        end

        // Long web hold still yields exactly one load.
        web_pad = 1'b0; loads = 0; last_val = '0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (cnt_load) begin loads++; last_val = cnt_load_val; end
        end
        check_output("hold.load_count", 64'(loads), 64'(1));
        check_output("hold.load_val", 64'(last_val), 64'(VP));
        check_output("hold.cnt_en", 64'(cnt_en), 64'(0));
        idle_inputs(5);
        check_output("hold.busy_after", 64'(busy), 64'(0));

        // Bus toggling every cycle must never settle into a load.
        notp = ~VP; loads = 0; idle_seen = 1'b0;
        web_pad = 1'b0;
        for (int c = 0; c < 12; c++) begin
            pad_in = c[0] ? VP : notp;
            step();
            if (cnt_load) loads++;
        end
        web_pad = 1'b1;
        for (int c = 0; c < 10 && !idle_seen; c++) begin
            pad_in = c[0] ? VP : notp;
            step();
            if (cnt_load) loads++;
            if (!busy) idle_seen = 1'b1;
        end
        check_output("toggle.load_count", 64'(loads), 64'(0));
        check_output("toggle.returns_idle", 64'(idle_seen), 64'(1));
        pad_in = VP;
        idle_inputs(3);

        // oeb and web together: write wins, no drive until web is released.
        oeb_pad = 1'b0; web_pad = 1'b0; loads = 0; drove = 1'b0; cnt_q = VA;
        for (int c = 0; c < 20; c++) begin
            step();
            if (cnt_load) loads++;
            if (pad_oe != '0) drove = 1'b1;
        end
        check_output("both.no_drive", 64'(drove), 64'(0));
        check_output("both.load_count", 64'(loads), 64'(1));
        web_pad = 1'b1;
        for (int c = 0; c < 5; c++) step();
        check_output("both.turn_hiz", 64'(pad_oe), 64'(0));
        step();
        check_output("both.drive_on", 64'(pad_oe), 64'(ALL1));
        step();
        check_output("both.pad_out", 64'(pad_out), 64'(VA));

        // Write request arriving while driving: turn around, then load the bus value.
        pad_in = VQ; cnt_q = VC;
        step(); step(); step();
        web_pad = 1'b0;
        step(); step();
        check_output("wdrv.still_drive", 64'(pad_oe), 64'(ALL1));
        step();
        check_output("wdrv.drop", 64'(pad_oe), 64'(0));
        for (int c = 0; c < 4; c++) step();
        check_output("wdrv.no_early_load", 64'(cnt_load), 64'(0));
        step();
        check_output("wdrv.load", 64'(cnt_load), 64'(1));
        check_output("wdrv.load_val", 64'(cnt_load_val), 64'(VQ));
        idle_inputs(8);
        check_output("wdrv.idle", 64'(busy), 64'(0));

        // Asynchronous reset in the middle of a drive.
        oeb_pad = 1'b0;
        for (int c = 0; c < 6; c++) step();
        check_output("arst.pre_drive", 64'(pad_oe), 64'(ALL1));
        #2;
        rst_n = 1'b0;
        #1;
        check_output("arst.pad_oe", 64'(pad_oe), 64'(0));
        check_output("arst.busy", 64'(busy), 64'(0));
        check_output("arst.cnt_en", 64'(cnt_en), 64'(0));
        oeb_pad = 1'b1;
        #1;
        rst_n = 1'b1;
        step();
        check_output("arst.rel_cnt_en", 64'(cnt_en), 64'(1));
        check_output("arst.rel_busy", 64'(busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
